// File: rtl/detector_jogada.sv
// Button input conditioner for the Genius game: 2-FF synchroniser, debounce FSM, one-hot validation.
// Optional inactivity flag enabled by defining DETECTOR_TIMEOUT_EN; otherwise timeout is tied to 0.
module detector_jogada #(
   parameter int DEBOUNCE_CYCLES = 5,
   parameter int TIMEOUT_CYCLES  = 3000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] botoes,
   input  logic       habilita,
   input  logic       limpa,
   output logic       jogada_feita,
   output logic [3:0] jogada,
   output logic       jogada_invalida,
   output logic       timeout,
   output logic [2:0] db_estado
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      ESPERA  = 3'd0,
      FILTRA  = 3'd1,
      VALIDA  = 3'd2,
      SOLTURA = 3'd3
   } estado_t;

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be >= 1");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be >= 1");
   end

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   logic [3:0]       sync_p0, sync_p1;
   logic [3:0]       s;
   estado_t          state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [3:0]       cand, cand_nx;
   logic [3:0]       jogada_nx;
   logic             capture;

   // stage p0/p1: two-flop synchroniser for the asynchronous buttons
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_p0 <= 4'd0;
         sync_p1 <= 4'd0;
      end else begin
         sync_p0 <= botoes;
         sync_p1 <= sync_p0;
      end
   end

   assign s = sync_p1;

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      cand_nx   = cand;
      capture   = 1'b0;
      case (state)
         ESPERA: begin
            if (habilita && (s != 4'd0)) begin
               state_nx = FILTRA;
               cand_nx  = s;
               cnt_nx   = '0;
            end
         end
         FILTRA: begin
            if (s != cand) begin
               state_nx = ESPERA;
            end else if (!habilita) begin
               // abandoned mid-filter: still demand a clean release before re-arming
               state_nx = SOLTURA;
               cnt_nx   = '0;
            end else if (cnt == CNT_MAX) begin
               state_nx = VALIDA;
               capture  = is_onehot(cand);
            end else begin
               cnt_nx = sat_inc(cnt);
            end
         end
         VALIDA: begin
            state_nx = SOLTURA;
            cnt_nx   = '0;
         end
         SOLTURA: begin
            if (s != 4'd0) begin
               cnt_nx = '0;
            end else if (cnt == CNT_MAX) begin
               state_nx = ESPERA;
            end else begin
               cnt_nx = sat_inc(cnt);
            end
         end
         default: begin
            state_nx = ESPERA;
            cnt_nx   = '0;
         end
      endcase
   end

   // capture takes priority over a coincident clear
   always_comb begin
      jogada_nx = jogada;
      if (capture) begin
         jogada_nx = cand;
      end else if (limpa) begin
         jogada_nx = 4'd0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= ESPERA;
         cnt    <= '0;
         cand   <= 4'd0;
         jogada <= 4'd0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         cand   <= cand_nx;
         jogada <= jogada_nx;
      end
   end

   assign jogada_feita    = (state == VALIDA) &&  is_onehot(cand);
   assign jogada_invalida = (state == VALIDA) && !is_onehot(cand);
   assign db_estado       = state;

`ifdef DETECTOR_TIMEOUT_EN
   localparam int TCNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYCLES - 1);

   logic [TCNT_W-1:0] tcnt;

   // idle counter only runs while waiting for a press with the UC listening
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tcnt <= '0;
      end else if (!habilita || (state != ESPERA)) begin
         tcnt <= '0;
      end else if (tcnt != TCNT_MAX) begin
         tcnt <= tcnt + TCNT_W'(1);
      end
   end

   assign timeout = (tcnt == TCNT_MAX);
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Scoreboard bench for detector_jogada: stimulus queues expected pulses, a monitor pops them on each pulse.
// Timeout section expectations follow DETECTOR_TIMEOUT_EN.
module tb_detector_jogada;

   logic       clock;
   logic       reset;
   logic [3:0] botoes;
   logic       habilita;
   logic       limpa;
   logic       jogada_feita;
   logic [3:0] jogada;
   logic       jogada_invalida;
   logic       timeout;
   logic [2:0] db_estado;

`ifdef DETECTOR_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif

   typedef struct {
      logic       feita;
      logic [3:0] jog;
      int         cyc;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   detector_jogada #(
      .DEBOUNCE_CYCLES(5),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .botoes         (botoes),
      .habilita       (habilita),
      .limpa          (limpa),
      .jogada_feita   (jogada_feita),
      .jogada         (jogada),
      .jogada_invalida(jogada_invalida),
      .timeout        (timeout),
      .db_estado      (db_estado)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   // monitor: every pulse must match the oldest queued expectation
   always @(negedge clock) begin
      if (reset === 1'b1 && (jogada_feita || jogada_invalida)) begin
         chk("pulses_exclusive", 32'(jogada_feita & jogada_invalida), 32'd0);
         if (sbq.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_pulse: feita=%0b invalida=%0b jogada=%b at cycle %0d, none expected",
                     jogada_feita, jogada_invalida, jogada, cyc);
         end else begin
            e = sbq.pop_front();
            chk("pulse_kind",   32'(jogada_feita), 32'(e.feita));
            chk("pulse_cycle",  32'(cyc),          32'(e.cyc));
            chk("pulse_jogada", 32'(jogada),       32'(e.jog));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c, r, p;
      reset    = 1'b0;
      botoes   = 4'd0;
      habilita = 1'b0;
      limpa    = 1'b0;

      idle(2);
      chk("rst_db_estado", 32'(db_estado),       32'd0);
      chk("rst_jogada",    32'(jogada),          32'd0);
      chk("rst_feita",     32'(jogada_feita),    32'd0);
      chk("rst_invalida",  32'(jogada_invalida), 32'd0);
      chk("rst_timeout",   32'(timeout),         32'd0);
      habilita = 1'b1;
      reset    = 1'b1;
      idle(3);

      // single clean press 0010, held 10 cycles
      c = cyc;
      botoes = 4'b0010;
      sbq.push_back('{feita: 1'b1, jog: 4'b0010, cyc: c + 8});
      idle(10);
      botoes = 4'd0;
      idle(6);
      chk("s1_soltura", 32'(db_estado), 32'd3);
      idle(1);
      chk("s1_espera",  32'(db_estado), 32'd0);
      idle(5);

      // bounce: 3 on, 1 off, 10 on
      c = cyc;
      botoes = 4'b0100;
      sbq.push_back('{feita: 1'b1, jog: 4'b0100, cyc: c + 12});
      idle(3);
      botoes = 4'd0;
      idle(1);
      botoes = 4'b0100;
      idle(10);
      botoes = 4'd0;
      idle(12);
      chk("s2_espera", 32'(db_estado), 32'd0);

      // two buttons at once: invalid pulse, jogada kept
      c = cyc;
      botoes = 4'b0011;
      sbq.push_back('{feita: 1'b0, jog: 4'b0100, cyc: c + 8});
      idle(10);
      botoes = 4'd0;
      idle(10);
      chk("s3_jogada_kept", 32'(jogada),    32'h4);
      chk("s3_espera",      32'(db_estado), 32'd0);

      // disabled: press ignored, then clear
      habilita = 1'b0;
      botoes = 4'b1000;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("s4_stays_espera", 32'(db_estado), 32'd0);
      end
      botoes = 4'd0;
      chk("s4_before_limpa", 32'(jogada), 32'h4);
      limpa = 1'b1;
      @(negedge clock);
      limpa = 1'b0;
      chk("s4_limpa", 32'(jogada), 32'd0);
      habilita = 1'b1;
      idle(3);

      // limpa coinciding with the capture edge: capture wins
      c = cyc;
      botoes = 4'b0001;
      sbq.push_back('{feita: 1'b1, jog: 4'b0001, cyc: c + 8});
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         limpa = (i == 7);
      end
      botoes = 4'd0;
      idle(10);
      chk("coll_jogada", 32'(jogada), 32'h1);

      // asynchronous reset in the middle of filtering
      botoes = 4'b0010;
      idle(4);
      chk("s5_in_filtra", 32'(db_estado), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("s5_db_estado", 32'(db_estado),       32'd0);
      chk("s5_jogada",    32'(jogada),          32'd0);
      chk("s5_feita",     32'(jogada_feita),    32'd0);
      chk("s5_invalida",  32'(jogada_invalida), 32'd0);
      chk("s5_timeout",   32'(timeout),         32'd0);
      botoes = 4'd0;
      @(negedge clock);
      reset = 1'b1;
      r = cyc;

      // inactivity with habilita=1 and no press
      idle(18);
      chk("s6_timeout_before", 32'(timeout), 32'd0);
      idle(1);
      chk("s6_timeout_rise",   32'(timeout), 32'(TO_EN));
      idle(6);
      chk("s6_timeout_held",   32'(timeout), 32'(TO_EN));
      p = cyc;
      botoes = 4'b0001;
      sbq.push_back('{feita: 1'b1, jog: 4'b0001, cyc: p + 8});
      idle(4);
      chk("s6_timeout_cleared", 32'(timeout), 32'd0);
      idle(6);
      botoes = 4'd0;
      idle(12);
      chk("s6_espera", 32'(db_estado), 32'd0);
      if (r < 0) $display("r=%0d", r);

      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
